// File: rtl/spi_byte_tx.sv
// SPI mode-0 master transmitter: one DATA_W-bit word per frame, MSB first.
// Ports: i_clk, i_rst_n, i_data/i_valid/o_ready in; o_sck/o_mosi/o_cs_n/o_done/o_busy out.
module spi_byte_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_sck,
  output logic              o_mosi,
  output logic              o_cs_n,
  output logic              o_done,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [3:0] BITS    = 4'(DATA_W);

  state_t            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_next;
  logic              sck_d, mosi_d, cs_d, done_d;
  logic              tick;

  assign tick    = (div_q == DIV_MAX);
  assign sh_next = sh_q << 1;
  assign o_ready = (state_q == IDLE);
  assign o_busy  = ~o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      o_sck   <= 1'b0;
      o_mosi  <= 1'b0;
      o_cs_n  <= 1'b1;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      o_sck   <= sck_d;
      o_mosi  <= mosi_d;
      o_cs_n  <= cs_d;
      o_done  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sck_d   = o_sck;
    mosi_d  = o_mosi;
    cs_d    = o_cs_n;
    done_d  = 1'b0;
    if (state_q != IDLE) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          sh_d    = i_data;
          mosi_d  = i_data[DATA_W-1];
          cs_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          bit_d   = bit_q + 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!o_sck) begin
            sck_d = 1'b1;
            bit_d = bit_q + 4'd1;
          end else begin
            sck_d = 1'b0;
            // last falling edge keeps the LSB on the line
            if (bit_q == BITS) begin
              state_d = HOLD;
            end else begin
              sh_d   = sh_next;
              mosi_d = sh_next[DATA_W-1];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_byte_tx.sv
// Self-checking bench for spi_byte_tx (CLK_DIV=4 and CLK_DIV=1 instances).
// Expected bits are queued at accept and popped at each SCK rising edge.
module tb_spi_byte_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       rdy0, sck0, mosi0, cs0, done0, busy0;
  logic       rdy1, sck1, mosi1, cs1, done1, busy1;

  spi_byte_tx #(.CLK_DIV(4), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(d0), .i_valid(v0), .o_ready(rdy0),
    .o_sck(sck0), .o_mosi(mosi0), .o_cs_n(cs0),
    .o_done(done0), .o_busy(busy0)
  );

  spi_byte_tx #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(d1), .i_valid(v1), .o_ready(rdy1),
    .o_sck(sck1), .o_mosi(mosi1), .o_cs_n(cs1),
    .o_done(done1), .o_busy(busy1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  // Returns at the negedge right after the accept edge.
  task automatic send(input bit sel, input logic [7:0] w,
                      input bit keep);
    int n = 0;
    @(negedge clk);
    while (!(sel ? rdy1 : rdy0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_ready: ready=0 required 1");
    end
    if (sel) begin d1 = w; v1 = 1'b1; end
    else     begin d0 = w; v0 = 1'b1; end
    push_word(w);
    @(negedge clk);
    if (!keep) begin
      if (sel) v1 = 1'b0;
      else     v0 = 1'b0;
    end
  endtask

  task automatic watch(input bit sel, input int div,
                       input int nframes, input int budget);
    int start = -1;
    int last_done = -1;
    int rises = 0;
    int frames = 0;
    int t = 0;
    int off;
    logic psck = 1'b0;
    logic pcs = 1'b1;
    logic s, m, c, dn;
    bit e;
    while (frames < nframes && t < budget) begin
      s  = sel ? sck1 : sck0;
      m  = sel ? mosi1 : mosi0;
      c  = sel ? cs1 : cs0;
      dn = sel ? done1 : done0;
      if (pcs && !c) begin
        start = cyc;
        rises = 0;
        if (last_done >= 0) begin
          checks++;
          if (start - last_done !== 1) begin
            errors++;
            $display("FAIL cs_gap: got %0d required 1",
                     start - last_done);
          end
        end
      end
      if (c !== pcs) begin
        checks++;
        if (s !== 1'b0) begin
          errors++;
          $display("FAIL sck_at_cs: sck=%b required 0", s);
        end
      end
      off = cyc - start;
      if (s && !psck) begin
        checks++;
        if (off !== div * (2 * rises + 1)) begin
          errors++;
          $display("FAIL rise_time: off=%0d required %0d",
                   off, div * (2 * rises + 1));
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_rise: off=%0d required none", off);
        end else begin
          e = exp_q.pop_front();
          if (m !== e) begin
            errors++;
            $display("FAIL mosi_bit%0d: got %b required %b",
                     rises, m, e);
          end
        end
        rises++;
      end
      if (dn) begin
        checks++;
        if (off !== 17 * div || c !== 1'b1) begin
          errors++;
          $display("FAIL done_time: off=%0d cs=%b required %0d/1",
                   off, c, 17 * div);
        end
        checks++;
        if (rises !== 8) begin
          errors++;
          $display("FAIL rise_count: got %0d required 8", rises);
        end
        frames++;
        last_done = cyc;
      end
      psck = s;
      pcs  = c;
      if (frames < nframes) begin
        @(negedge clk);
        t++;
      end
    end
    checks++;
    if (frames != nframes) begin
      errors++;
      $display("FAIL frame_timeout: frames=%0d required %0d",
               frames, nframes);
    end
  endtask

  task automatic test_reset;
    bit bad;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      bad = (rdy0 !== 1) || (cs0 !== 1) || (sck0 !== 0) ||
            (mosi0 !== 0) || (done0 !== 0) || (busy0 !== 0) ||
            (rdy1 !== 1) || (cs1 !== 1) || (sck1 !== 0) ||
            (mosi1 !== 0) || (done1 !== 0) || (busy1 !== 0);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL reset_idle: rdy=%b cs=%b sck=%b mosi=%b done=%b busy=%b required 1 1 0 0 0 0",
                 rdy0, cs0, sck0, mosi0, done0, busy0);
      end
    end
  endtask

  task automatic test_a5;
    send(1'b0, 8'hA5, 1'b0);
    checks++;
    if (cs0 !== 1'b0) begin
      errors++;
      $display("FAIL cs_fall: cs=%b required 0", cs0);
    end
    watch(1'b0, 4, 1, 200);
  endtask

  task automatic test_back_to_back;
    send(1'b0, 8'h3C, 1'b1);
    d0 = 8'hFF;
    push_word(8'hFF);
    fork
      watch(1'b0, 4, 2, 400);
      begin
        int k = 0;
        while (!done0 && k < 200) begin
          @(negedge clk);
          k++;
        end
        @(negedge clk);
        v0 = 1'b0;
      end
    join
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_left: %0d bits left required 0",
               exp_q.size());
    end
  endtask

  task automatic test_ignore;
    bit bad = 0;
    send(1'b0, 8'h81, 1'b0);
    fork
      watch(1'b0, 4, 1, 200);
      begin
        repeat (60) begin
          @(negedge clk);
          v0 = 1'($urandom);
          d0 = 8'($urandom);
        end
        v0 = 1'b0;
      end
    join
    repeat (10) begin
      @(negedge clk);
      if (cs0 !== 1'b1 || rdy0 !== 1'b1 || done0 !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_extra_accept: cs=%b rdy=%b required 1 1",
               cs0, rdy0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_left: %0d bits left required 0",
               exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    bit bad = 0;
    send(1'b0, 8'hC3, 1'b0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sck0 !== 1'b0 || cs0 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: sck=%b cs=%b required 0 1",
               sck0, cs0);
    end
    checks++;
    if (rdy0 !== 1'b1 || mosi0 !== 1'b0) begin
      errors++;
      $display("FAIL async_state: rdy=%b mosi=%b required 1 0",
               rdy0, mosi0);
    end
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (done0 !== 1'b0 || cs0 !== 1'b1) bad = 1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done0 !== 1'b0 || cs0 !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL dropped_frame: done=%b cs=%b required 0 1",
               done0, cs0);
    end
    send(1'b0, 8'h5A, 1'b0);
    watch(1'b0, 4, 1, 200);
  endtask

  task automatic test_div1;
    send(1'b1, 8'h01, 1'b0);
    watch(1'b1, 1, 1, 100);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL div1_left: %0d bits left required 0",
               exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_ignore();
    test_mid_reset();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spi_byte_tx.md
Name: spi_byte_tx

Overview:
- SPI mode-0 master transmitter.
- Serialises one DATA_W-bit word per frame, MSB first, on o_mosi, and drives o_sck and o_cs_n itself.
- It is the sending end of the link whose receiver counts 8 SCK edges per byte.
- Sits between the byte source (valid/ready handshake) and the chip pins; o_done reports frame completion to the controlling logic.

Parameters:
- CLK_DIV, 4: i_clk cycles per SCK half-period; legal range 1..255.
- DATA_W, 8: bits per frame; legal range 1..15; bit counter is 4 bits.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  DATA_W  word to transmit; sampled only on the accept cycle.
- i_valid  input  1  source has a word.
- o_ready  output  1  block idle and able to accept.
- o_sck  output  1  SPI clock; idles low.
- o_mosi  output  1  serial data; changes only while o_sck is low.
- o_cs_n  output  1  chip select, active low.
- o_done  output  1  one-cycle pulse at end of frame.
- o_busy  output  1  equals ~o_ready.

Behaviour:
- Reset, asynchronous, any time including mid-frame:
  - state=IDLE, o_sck=0, o_cs_n=1, o_mosi=0, o_done=0, o_ready=1.
  - Shift register, divider counter and bit counter are cleared.
  - The interrupted frame is dropped, with no o_done pulse.
- States: IDLE, SETUP, SHIFT, HOLD. o_ready=1 only in IDLE.
- Accept: at a rising edge E0 where i_valid & o_ready:
  - i_data is latched into the shift register; state -> SETUP.
  - o_cs_n=0 and o_mosi=i_data[DATA_W-1] after E0.
- While busy, i_valid and i_data are ignored.
- Divider: counter 0..CLK_DIV-1 runs in SETUP, SHIFT and HOLD. tick = (counter==CLK_DIV-1); the counter wraps to 0 on tick.
- SETUP: on the first tick (edge E0+CLK_DIV), o_sck goes to 1 and state -> SHIFT.
- SHIFT: o_sck toggles on every tick.
  - Rising SCK edges occur at E0+CLK_DIV*(2k+1), k=0..DATA_W-1.
  - Falling SCK edges occur at E0+CLK_DIV*(2k+2).
  - On each falling edge except the last, the shift register shifts left and o_mosi takes the next bit.
  - The bit counter increments on each rising edge.
  - The last falling edge (bit counter == DATA_W) goes to HOLD, with o_sck=0 and o_mosi holding the LSB.
- HOLD: o_cs_n stays low for one more half-period. At the tick (edge E0+(2*DATA_W+1)*CLK_DIV):
  - o_cs_n=1, o_done=1 for exactly one cycle.
  - state -> IDLE, o_ready=1.
- Frame length: (2*DATA_W+1)*CLK_DIV cycles from accept to o_done. Default: 68 cycles.
- Back-to-back: the earliest next accept is the edge after o_done, so o_cs_n is high for at least 1 cycle between frames. i_valid held high gives frames every (2*DATA_W+1)*CLK_DIV+1 cycles.
- o_sck has exactly DATA_W rising edges per frame and never glitches. It is low whenever o_cs_n toggles.
- CLK_DIV=1: SCK = i_clk/2. Timing formulas above still hold.
- All outputs are registered except o_ready and o_busy, which decode state.

Test Plan:
- Reset release, i_valid=0 for 20 cycles -> o_ready=1, o_cs_n=1, o_sck=0, o_mosi=0, o_done=0 throughout.
- CLK_DIV=4, send 8'hA5 -> o_cs_n falls 1 edge after accept; 8 o_sck rising edges at offsets 4,12,...,60; o_mosi sampled at those edges = 1,0,1,0,0,1,0,1; o_done pulse at offset 68 coincident with o_cs_n rising.
- Two words 8'h3C then 8'hFF with i_valid held high -> second accept on the cycle after o_done; o_cs_n high exactly 1 cycle; bits 00111100 then 11111111.
- i_valid toggling and i_data changing every cycle during a frame of 8'h81 -> transmitted bits remain 10000001; no extra accept.
- Assert i_rst_n low at offset 30 of a frame -> o_sck=0 and o_cs_n=1 immediately (asynchronously); no o_done; next frame 8'h5A after release is correct.
- CLK_DIV=1, DATA_W=8, send 8'h01 -> frame is 17 cycles; o_sck period 2 cycles; final bit 1 sampled on the 8th rising edge.
